// File: rtl/fifo_traffic_pkg.sv
// fifo_traffic_pkg: shared state encoding and LFSR constants for the FIFO traffic generator
package fifo_traffic_pkg;
   typedef enum logic [2:0] {IDLE, FILL, DRAIN, MIXED, FLUSH, DONE} state_t;
   localparam logic [15:0] lfsr_taps = 16'hB400;
   localparam logic [15:0] lfsr_seed = 16'hACE1;
endpackage

// File: rtl/fifo_traffic_gen_lfsr16.sv
// lfsr16: 16-bit Galois LFSR that steps only when enabled and resets to the seed
module lfsr16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] q
);
   import fifo_traffic_pkg::*;
   logic [15:0] state_q, state_d;
   // shift right, folding the taps in whenever a one falls out of the bottom
   always_comb begin
      state_d = !en ? state_q : state_q[0] ? (state_q >> 1) ^ lfsr_taps : state_q >> 1;
   end
   // state register, seeded on reset so the sequence never sits at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= lfsr_seed;
      else state_q <= state_d;
   end
   assign q = state_q;
endmodule

// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: drives a FIFO through fill, drain, random mixed and flush phases and checks read order
module fifo_traffic_gen #(
   parameter int width = 8,
   parameter int depth = 4,
   parameter bit allow_push_when_full_with_pop = 1'b0,
   parameter int n_transfers = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             push,
   output logic             pop,
   output logic [width-1:0] write_data,
   input  logic [width-1:0] read_data,
   input  logic             empty,
   input  logic             full,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [7:0]       err_count
);
   import fifo_traffic_pkg::*;
   localparam int cw = $clog2(n_transfers + 1);
   localparam logic [cw-1:0] last_push = cw'(n_transfers - 1);
   localparam bit can_fill = depth > 0;
   state_t state_q, state_d;
   logic [width-1:0] wr_seq_q, wr_seq_d, rd_seq_q, rd_seq_d;
   logic [cw-1:0] push_cnt_q, push_cnt_d;
   logic error_q, error_d, busy_q, busy_d, done_q, done_d;
   logic [7:0] err_count_q, err_count_d;
   logic [15:0] lfsr;
   logic lfsr_unused;
   logic mism;
   lfsr16 u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (state_q == MIXED),
      .q   (lfsr)
   );
   assign lfsr_unused = ^lfsr[15:2];
   // FIFO requests, gated by the flags so the FIFO is never over- or under-run
   always_comb begin
      pop = (state_q == DRAIN || state_q == FLUSH) ? ~empty :
            (state_q == MIXED) ? lfsr[1] & ~empty : 1'b0;
      push = (state_q == FILL) ? ~full & can_fill :
             (state_q == MIXED) ? lfsr[0] & (~full | (allow_push_when_full_with_pop & pop)) : 1'b0;
   end
   // phase sequencing, sequence counters and the read-order checker
   always_comb begin
      state_d = state_q;
      wr_seq_d = push ? wr_seq_q + 1'b1 : wr_seq_q;
      rd_seq_d = pop ? rd_seq_q + 1'b1 : rd_seq_q;
      push_cnt_d = push ? push_cnt_q + 1'b1 : push_cnt_q;
      mism = pop && (read_data != rd_seq_q);
      error_d = error_q | mism;
      err_count_d = (mism && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = FILL;
            wr_seq_d = '0;
            rd_seq_d = '0;
            push_cnt_d = '0;
         end
         FILL: state_d = full ? DRAIN : (push && push_cnt_q == last_push) ? FLUSH : FILL;
         DRAIN: state_d = empty ? MIXED : DRAIN;
         MIXED: state_d = (push && push_cnt_q == last_push) ? FLUSH : MIXED;
         FLUSH: state_d = empty ? DONE : FLUSH;
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
      done_d = state_d == DONE;
   end
   // all state flops; reset aborts any run in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wr_seq_q <= '0;
         rd_seq_q <= '0;
         push_cnt_q <= '0;
         error_q <= 1'b0;
         err_count_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_seq_q <= wr_seq_d;
         rd_seq_q <= rd_seq_d;
         push_cnt_q <= push_cnt_d;
         error_q <= error_d;
         err_count_q <= err_count_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign write_data = wr_seq_q;
   assign busy = busy_q;
   assign done = done_q;
   assign error = error_q;
   assign err_count = err_count_q;
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb_fifo_traffic_gen: scoreboard bench with behavioural FIFOs for the traffic generator
module tb_fifo_traffic_gen;
   import fifo_traffic_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic start_v [2];
   logic frc = 1'b0, f_full = 1'b0, f_empty = 1'b1, corrupt = 1'b0;
   logic push_a, pop_a, busy_a, done_a, err_a;
   logic push_w, pop_w, busy_w, done_w, err_w;
   logic push_b, pop_b, busy_b, done_b, err_b;
   logic [7:0] wd_a, ec_a, ec_w, wd_b, ec_b;
   logic [3:0] wd4;
   logic push_v [2], pop_v [2], busy_v [2], done_v [2], err_v [2], full_v [2], empty_v [2];
   logic [7:0] wd_v [2], rd_v [2], ec_v [2];
   logic [7:0] mem [2][4];
   logic [1:0] wp [2], rp [2];
   logic [2:0] cnt [2];
   logic [7:0] wr_q [2][$];
   logic [8:0] err_q [2][$];
   logic [7:0] m_rd [2], m_cnt [2];
   logic m_err [2], popped [2];
   int fill_push [2];
   logic [8:0] e;
   logic mism;
   int n_chk = 0, n_pass = 0;

   fifo_traffic_gen #(.width(8), .depth(4), .allow_push_when_full_with_pop(1'b0), .n_transfers(20)) u_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .push(push_a), .pop(pop_a), .write_data(wd_a),
      .read_data(rd_v[0]), .empty(empty_v[0]), .full(full_v[0]), .busy(busy_a), .done(done_a),
      .error(err_a), .err_count(ec_a));
   fifo_traffic_gen #(.width(4), .depth(4), .allow_push_when_full_with_pop(1'b0), .n_transfers(40)) u_w (
      .clk(clk), .rst(rst), .start(start_v[1]), .push(push_w), .pop(pop_w), .write_data(wd4),
      .read_data(rd_v[1][3:0]), .empty(empty_v[1]), .full(full_v[1]), .busy(busy_w), .done(done_w),
      .error(err_w), .err_count(ec_w));
   fifo_traffic_gen #(.width(8), .depth(4), .allow_push_when_full_with_pop(1'b1), .n_transfers(20)) u_b (
      .clk(clk), .rst(rst), .start(start_v[0]), .push(push_b), .pop(pop_b), .write_data(wd_b),
      .read_data(8'h00), .empty(f_empty), .full(f_full), .busy(busy_b), .done(done_b),
      .error(err_b), .err_count(ec_b));

   assign push_v = '{push_a, push_w};
   assign pop_v = '{pop_a, pop_w};
   assign busy_v = '{busy_a, busy_w};
   assign done_v = '{done_a, done_w};
   assign err_v = '{err_a, err_w};
   assign ec_v = '{ec_a, ec_w};
   assign wd_v = '{wd_a, {4'h0, wd4}};
   assign full_v = '{frc ? f_full : cnt[0] == 3'd4, cnt[1] == 3'd4};
   assign empty_v = '{frc ? f_empty : cnt[0] == 3'd0, cnt[1] == 3'd0};
   assign rd_v = '{(corrupt && mem[0][rp[0]] == 8'h05) ? 8'h15 : mem[0][rp[0]], mem[1][rp[1]]};

   function automatic logic [7:0] msk(input int g);
      return g == 0 ? 8'hFF : 8'h0F;
   endfunction
   function automatic int nt(input int g);
      return g == 0 ? 20 : 40;
   endfunction
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ lfsr_taps) : (s >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // behavioural depth-4 FIFOs in front of the two free-running generators
   initial forever begin
      @(posedge clk);
      for (int g = 0; g < 2; g++) begin
         if (rst) begin
            wp[g] <= 2'd0;
            rp[g] <= 2'd0;
            cnt[g] <= 3'd0;
         end else if (!(g == 0 && frc)) begin
            if (pop_v[g] && cnt[g] != 3'd0) rp[g] <= rp[g] + 2'd1;
            if (push_v[g] && cnt[g] != 3'd4) begin
               mem[g][wp[g]] <= wd_v[g];
               wp[g] <= wp[g] + 2'd1;
            end
            cnt[g] <= cnt[g] + 3'(push_v[g] && cnt[g] != 3'd4) - 3'(pop_v[g] && cnt[g] != 3'd0);
         end
      end
   end

   // scoreboard: expected write data queued at start, expected error state queued at each pop
   initial forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         if (rst) begin
            wr_q[g].delete();
            err_q[g].delete();
            m_err[g] = 1'b0;
            m_cnt[g] = 8'd0;
         end else if (!(g == 0 && frc)) begin
            if (err_q[g].size() != 0) begin
               e = err_q[g].pop_front();
               check("error_flag", err_v[g], e[8]);
               check("err_count", ec_v[g], e[7:0]);
            end
            if (!busy_v[g]) begin
               m_rd[g] = 8'd0;
               fill_push[g] = 0;
               popped[g] = 1'b0;
               if (start_v[g]) begin
                  wr_q[g].delete();
                  for (int k = 0; k < nt(g); k++) wr_q[g].push_back(8'(k) & msk(g));
               end
            end
            if (push_v[g]) begin
               check("push_on_full", full_v[g], 1'b0);
               if (wr_q[g].size() == 0) check("push_extra", push_v[g], 1'b0);
               else check("write_data", wd_v[g], wr_q[g].pop_front());
               if (!popped[g]) fill_push[g]++;
            end
            if (pop_v[g]) begin
               check("pop_on_empty", empty_v[g], 1'b0);
               if (!popped[g]) check("fill_pushes", fill_push[g], 4);
               popped[g] = 1'b1;
               mism = rd_v[g] != (m_rd[g] & msk(g));
               m_err[g] = m_err[g] | mism;
               if (mism && m_cnt[g] != 8'hFF) m_cnt[g] = m_cnt[g] + 8'd1;
               err_q[g].push_back({m_err[g], m_cnt[g]});
               m_rd[g] = m_rd[g] + 8'd1;
            end
         end
      end
   end

   task automatic pulse(input int g);
      @(posedge clk); #1 start_v[g] = 1'b1;
      @(posedge clk); #1 start_v[g] = 1'b0;
   endtask

   task automatic wait_done(input int g);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         seen = done_v[g];
      end
      check("done_seen", seen, 1'b1);
      @(negedge clk);
      check("done_single", done_v[g], 1'b0);
      check("idle_after_done", busy_v[g], 1'b0);
   endtask

   task automatic end_checks(input int g, input logic err, input logic [7:0] ec);
      check("end_error", err_v[g], err);
      check("end_err_count", ec_v[g], ec);
      check("end_empty", empty_v[g], 1'b1);
      check("all_pushes", wr_q[g].size(), 0);
   endtask

   initial begin
      logic found;
      logic [15:0] m;
      int hits;
      start_v[0] = 1'b0;
      start_v[1] = 1'b0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check("rst_push", push_v[g], 1'b0);
         check("rst_pop", pop_v[g], 1'b0);
         check("rst_busy", busy_v[g], 1'b0);
         check("rst_done", done_v[g], 1'b0);
         check("rst_error", err_v[g], 1'b0);
         check("rst_err_count", ec_v[g], 8'd0);
         check("rst_write_data", wd_v[g], 8'd0);
      end
      @(posedge clk); #1 rst = 1'b0;
      pulse(0);
      wait_done(0);
      end_checks(0, 1'b0, 8'd0);
      corrupt = 1'b1;
      pulse(0);
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(negedge clk);
         found = pop_v[0] && rd_v[0] == 8'h15;
      end
      check("corrupt_pop_seen", found, 1'b1);
      check("error_before", err_v[0], 1'b0);
      @(negedge clk);
      check("error_after", err_v[0], 1'b1);
      check("err_count_after", ec_v[0], 8'd1);
      wait_done(0);
      corrupt = 1'b0;
      end_checks(0, 1'b1, 8'd1);
      @(posedge clk); #1 start_v[0] = 1'b1;
      wait_done(0);
      @(negedge clk);
      check("held_start_rerun", busy_v[0], 1'b1);
      @(posedge clk); #1 start_v[0] = 1'b0;
      wait_done(0);
      end_checks(0, 1'b1, 8'd1);
      @(posedge clk); #1 rst = 1'b1;
      frc = 1'b1;
      f_full = 1'b0;
      f_empty = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 start_v[0] = 1'b1;
      @(posedge clk); #1 start_v[0] = 1'b0;
      f_full = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 f_empty = 1'b0;
      m = lfsr_seed;
      hits = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("a0_pop", pop_v[0], m[1]);
         check("a0_push_full", push_v[0], 1'b0);
         check("a1_pop", pop_b, m[1]);
         check("a1_push_full", push_b, m[0] & m[1]);
         check("a1_write_data", wd_b, 8'(hits));
         if (m[0] & m[1]) hits++;
         m = lfsr_step(m);
      end
      check("a1_push_seen", hits > 0, 1'b1);
      check("a1_busy", busy_b, 1'b1);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      check("a1_rst_push", push_b, 1'b0);
      check("a1_rst_pop", pop_b, 1'b0);
      check("a1_rst_busy", busy_b, 1'b0);
      check("a1_rst_done", done_b, 1'b0);
      check("a1_rst_error", err_b, 1'b0);
      check("a1_rst_err_count", ec_b, 8'd0);
      @(posedge clk); #1 frc = 1'b0;
      f_full = 1'b0;
      f_empty = 1'b1;
      rst = 1'b0;
      pulse(0);
      repeat (15) @(negedge clk);
      check("mid_run_busy", busy_v[0], 1'b1);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      check("mid_rst_push", push_v[0], 1'b0);
      check("mid_rst_pop", pop_v[0], 1'b0);
      check("mid_rst_busy", busy_v[0], 1'b0);
      check("mid_rst_done", done_v[0], 1'b0);
      check("mid_rst_write_data", wd_v[0], 8'd0);
      @(posedge clk); #1 rst = 1'b0;
      pulse(0);
      wait_done(0);
      end_checks(0, 1'b0, 8'd0);
      pulse(1);
      wait_done(1);
      end_checks(1, 1'b0, 8'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
